// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam int SEG_W = SEG_G + 1;

   // active-high, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic {
      ST_BLANK,
      ST_ON
   } state_t;

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble to active-high segment pattern lookup.
module seg7_hex_dec
   import seg7_pkg::*;
(
   input  logic [3:0]       nib,
   output logic [SEG_W-1:0] seg_ah
);

   assign seg_ah = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner with tear-free frame update,
// dead time between digits and leading-zero suppression.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 100000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    lzs_en,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    value_vld,
   output logic [SEG_W-1:0]        seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW   = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] ON_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   localparam logic [SEG_W-1:0]      SEG_POL = {SEG_W{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};
   localparam logic                  DP_POL  = SEG_ACTIVE_LOW;

   state_t                st, st_nx;
   logic [IW-1:0]         idx, idx_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  fresh, fresh_nx;
   logic                  boundary;

   logic [VW-1:0]         shd_val, dsp_val, dsp_val_nx;
   logic [NUM_DIGITS-1:0] shd_dp, dsp_dp, dsp_dp_nx;

   logic [3:0]            nib;
   logic [SEG_W-1:0]      seg_dec;
   logic [NUM_DIGITS-1:0] zhi;
   logic                  lit, sup;
   logic [SEG_W-1:0]      seg_ah_nx;
   logic                  dp_ah_nx;
   logic [NUM_DIGITS-1:0] an_ah_nx;

   // fresh marks a scan start: the first ON visit is digit 0, not idx+1
   always_comb begin
      st_nx    = st;
      idx_nx   = idx;
      cnt_nx   = cnt + 1'b1;
      fresh_nx = fresh;
      boundary = 1'b0;
      if (!en) begin
         st_nx    = ST_BLANK;
         idx_nx   = '0;
         cnt_nx   = '0;
         fresh_nx = 1'b1;
      end else begin
         unique case (st)
            ST_BLANK: begin
               if (cnt == BL_LAST) begin
                  st_nx    = ST_ON;
                  cnt_nx   = '0;
                  fresh_nx = 1'b0;
                  boundary = fresh || (idx == IDX_LAST);
                  idx_nx   = boundary ? '0 : idx + 1'b1;
               end
            end
            ST_ON: begin
               if (cnt == ON_LAST) begin
                  st_nx  = ST_BLANK;
                  cnt_nx = '0;
               end
            end
            default: st_nx = ST_BLANK;
         endcase
      end
   end

   always_comb begin
      dsp_val_nx = dsp_val;
      dsp_dp_nx  = dsp_dp;
      if (boundary) begin
         dsp_val_nx = value_vld ? value_in : shd_val;
         dsp_dp_nx  = value_vld ? dp_in    : shd_dp;
      end
   end

   // zhi[i]: digit i and every higher digit are zero
   always_comb begin
      zhi = '0;
      zhi[NUM_DIGITS-1] = (dsp_val_nx[VW-1 -: 4] == 4'h0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         zhi[i] = zhi[i+1] && (dsp_val_nx[4*i +: 4] == 4'h0);
      end
   end

   assign nib = dsp_val_nx[4*int'(idx_nx) +: 4];

   seg7_hex_dec u_dec (
      .nib    (nib),
      .seg_ah (seg_dec)
   );

   always_comb begin
      lit       = (st_nx == ST_ON);
      sup       = lzs_en && (idx_nx != '0) && zhi[idx_nx];
      seg_ah_nx = (lit && !sup) ? seg_dec : '0;
      dp_ah_nx  = lit && dsp_dp_nx[idx_nx];
      an_ah_nx  = lit ? (NUM_DIGITS'(1) << idx_nx) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= ST_BLANK;
         idx        <= '0;
         cnt        <= '0;
         fresh      <= 1'b1;
         frame_done <= 1'b0;
         shd_val    <= '0;
         shd_dp     <= '0;
         dsp_val    <= '0;
         dsp_dp     <= '0;
         seg        <= SEG_POL;
         dp         <= DP_POL;
         an         <= AN_POL;
      end else begin
         st         <= st_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         fresh      <= fresh_nx;
         frame_done <= boundary;
         if (value_vld) begin
            shd_val <= value_in;
            shd_dp  <= dp_in;
         end
         dsp_val    <= dsp_val_nx;
         dsp_dp     <= dsp_dp_nx;
         seg        <= seg_ah_nx ^ SEG_POL;
         dp         <= dp_ah_nx ^ DP_POL;
         an         <= an_ah_nx ^ AN_POL;
      end
   end

endmodule
